keypad_scanner: RTL and testbench

- Drives the 4x4 keypad columns, which is the output direction of the keypad interface.
- Reads row lines that have already passed through the two-flop synchronizer.
- Debounces both press and release, then emits one key code per press.
- Sits between the synchronizer and the display/digit-history logic. It asserts scan_stop while a key is captured, so the column drive stays frozen.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_timer.sv | 40 ++++
 rtl/keypad_scanner.sv | 218 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// Holds the scanner state encoding, the row/column keymap, the idle column
// drive pattern and the helpers that pick a row and build a column drive.
package keypad_pkg;

  // Scanner states: rotating columns, confirming a press, waiting for the
  // release to settle, and the single hand-off cycle back into scanning.
  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  // Column drive after reset: column 0 pulled low, the rest released.
  localparam logic [3:0] COL_IDLE = 4'b1110;

  // Row pattern with no key pressed (rows are active-low).
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Key code indexed as KEYMAP[row][column].
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Lowest-index low row wins when several rows are pulled low together.
  // An all-high pattern never reaches this function in practice; it falls
  // through to row 3 so the result is always defined.
  function automatic logic [1:0] row_priority(input logic [3:0] rows_n);
    logic [1:0] idx;
    if (!rows_n[0]) begin
      idx = 2'd0;
    end else if (!rows_n[1]) begin
      idx = 2'd1;
    end else if (!rows_n[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // One-hot-low column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] col);
    logic [3:0] drive;
    drive = ~(4'b0001 << col);
    return drive;
  endfunction

endpackage

// File: rtl/keypad_timer.sv
// keypad_timer: loadable up-counter with a terminal-count flag.
// The count clears on clr, advances on inc, and saturates at the terminal
// value so it can never wrap past it. at_term reports count == term and is
// used by the scanner for column dwell, press/release debounce and repeat.
module keypad_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] term,
  output logic             at_term
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: clear wins over increment, and the count parks at term.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != term)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_term = (count_q == term);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the 4x4 keypad columns one at a time, watches the
// already-synchronized active-low rows, debounces both press and release
// and emits one key code per press. scan_stop is high while the column
// drive is frozen on a captured key.
// Optional feature: define KEYPAD_SCANNER_REPEAT_EN to re-pulse key_valid
// every REPEAT_CYCLES cycles while the captured key stays pressed.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       scan_stop
);

  import keypad_pkg::*;

  // The dwell must cover the two-flop synchronizer plus settling time, and
  // the cycle counts must be at least one for the terminal compare to work.
  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_DIV must be >= 4 and cycle counts >= 1");
  end

  // One shared timer covers dwell in SCAN and debounce/release elsewhere,
  // so it is sized for the larger of the two terminal counts.
  localparam int MAIN_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAIN_W   = $clog2(MAIN_MAX + 1);

  localparam logic [MAIN_W-1:0] DWELL_LAST = MAIN_W'(SCAN_DIV - 1);
  localparam logic [MAIN_W-1:0] DB_TERM    = MAIN_W'(DEBOUNCE_CYCLES);

  state_e     state_d;
  state_e     state_q;
  logic [1:0] col_d;
  logic [1:0] col_q;
  logic [3:0] cols_n_d;
  logic [3:0] cols_n_q;
  logic [3:0] latched_d;
  logic [3:0] latched_q;
  logic [3:0] key_code_d;
  logic [3:0] key_code_q;
  logic       key_valid_d;
  logic       key_valid_q;
  logic       key_held_d;
  logic       key_held_q;
  logic       scan_stop_d;
  logic       scan_stop_q;

  logic              tmr_clr;
  logic              tmr_inc;
  logic [MAIN_W-1:0] tmr_term;
  logic              tmr_at_term;

  logic rows_idle;

  assign rows_idle = (rows_n == ROWS_IDLE);

  // The timer's terminal depends only on the current state, which keeps the
  // at_term flag free of any loop through the next-state logic.
  assign tmr_term = (state_q == SCAN) ? DWELL_LAST : DB_TERM;

  keypad_timer #(
    .WIDTH (MAIN_W)
  ) u_main_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .term    (tmr_term),
    .at_term (tmr_at_term)
  );

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic rep_clr;
  logic rep_inc;
  logic rep_at_term;

  // Repeat interval timer; it only runs in HELD while a row is still low.
  keypad_timer #(
    .WIDTH (REP_W)
  ) u_repeat_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (rep_clr),
    .inc     (rep_inc),
    .term    (REP_LAST),
    .at_term (rep_at_term)
  );
`endif

  // Next-state and next-output logic for the scan/debounce/hold sequence.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cols_n_d    = cols_n_q;
    latched_d   = latched_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    scan_stop_d = scan_stop_q;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
    rep_clr     = 1'b1;
    rep_inc     = 1'b0;
`endif

    case (state_q)
      SCAN: begin
        if (tmr_at_term) begin
          tmr_clr = 1'b1;
          if (rows_idle) begin
            col_d    = col_q + 2'd1;
            cols_n_d = col_drive(col_q + 2'd1);
          end else begin
            latched_d   = rows_n;
            scan_stop_d = 1'b1;
            state_d     = DEBOUNCE;
          end
        end else begin
          tmr_inc = 1'b1;
        end
      end

      DEBOUNCE: begin
        if (tmr_at_term) begin
          tmr_clr     = 1'b1;
          key_code_d  = KEYMAP[row_priority(latched_q)][col_q];
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else if (rows_n == latched_q) begin
          tmr_inc = 1'b1;
        end else begin
          tmr_clr     = 1'b1;
          scan_stop_d = 1'b0;
          state_d     = SCAN;
        end
      end

      HELD: begin
        if (tmr_at_term) begin
          tmr_clr    = 1'b1;
          key_held_d = 1'b0;
          state_d    = RELEASE_DB;
        end else if (rows_idle) begin
          tmr_inc = 1'b1;
        end else begin
          tmr_clr = 1'b1;
`ifdef KEYPAD_SCANNER_REPEAT_EN
          if (rep_at_term) begin
            key_valid_d = 1'b1;
            rep_clr     = 1'b1;
          end else begin
            rep_clr = 1'b0;
            rep_inc = 1'b1;
          end
`endif
        end
      end

      RELEASE_DB: begin
        tmr_clr     = 1'b1;
        scan_stop_d = 1'b0;
        col_d       = col_q + 2'd1;
        cols_n_d    = col_drive(col_q + 2'd1);
        state_d     = SCAN;
      end

      default: begin
        tmr_clr     = 1'b1;
        scan_stop_d = 1'b0;
        key_held_d  = 1'b0;
        state_d     = SCAN;
      end
    endcase
  end

  // State and registered outputs; reset abandons any press in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      cols_n_q    <= COL_IDLE;
      latched_q   <= ROWS_IDLE;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      scan_stop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cols_n_q    <= cols_n_d;
      latched_q   <= latched_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      scan_stop_q <= scan_stop_d;
    end
  end

  assign cols_n    = cols_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign scan_stop = scan_stop_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a key-code
// scoreboard. Expected codes are queued when a press is driven and popped
// whenever key_valid pulses. Build with KEYPAD_SCANNER_REPEAT_EN defined to
// exercise the auto-repeat path as well.
module tb_keypad_scanner;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int REPEAT_CYCLES   = 20;

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       scan_stop;

  int total = 0;
  int bad = 0;
  int valid_count = 0;
  int exp_pulses = 0;

  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .scan_stop (scan_stop)
  );

  // Expected column drive for a column index (one-hot-low).
  function automatic logic [3:0] colPattern(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rows, input int cycles);
    rows_n = rows;
    repeat (cycles) @(negedge clk);
  endtask

  // Wait until cols_n freshly lands on target (leave it first if already there).
  task automatic waitCols(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (cols_n === target && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (cols_n !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, cols_n, target);
  endtask

  // Scoreboard: every key_valid pulse must match the oldest queued code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_key_valid", {31'b0, key_valid}, 32'h0);
      end else begin
        checkOutput("key_code_pulse", key_code, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] prev;
    int n;

    // Reset held for three edges with no keys pressed.
    reset  = 1'b0;
    rows_n = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("rst_cols_n", cols_n, 4'b1110);
    checkOutput("rst_key_code", key_code, 4'h0);
    checkOutput("rst_key_valid", key_valid, 1'b0);
    checkOutput("rst_key_held", key_held, 1'b0);
    checkOutput("rst_scan_stop", scan_stop, 1'b0);
    reset = 1'b1;

    // Free-running scan: each column dwells SCAN_DIV cycles.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checkOutput("scan_cols_n", cols_n, colPattern((i / SCAN_DIV) % 4));
    end

    // Press bounce on column 1: no capture, columns only ever step forward.
    waitCols(4'b1101, "bounce_start_col");
    prev = cols_n;
    for (int i = 0; i < 30; i++) begin
      rows_n = (((i / 3) % 2) == 0) ? 4'b1101 : 4'b1111;
      @(negedge clk);
      if (cols_n !== prev) begin
        checkOutput("bounce_col_step", cols_n, {prev[2:0], prev[3]});
        prev = cols_n;
      end
    end
    rows_n = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cols_n !== prev) begin
        checkOutput("resume_col_step", cols_n, {prev[2:0], prev[3]});
        prev = cols_n;
      end
    end
    checkOutput("bounce_valid_count", valid_count, 0);

    // Clean press of row 1 / column 1 -> key 5.
    waitCols(4'b1101, "press_start_col");
    rows_n = 4'b1101;
    exp_q.push_back(4'h5);
    exp_pulses = exp_pulses + 1;
    repeat (3) @(negedge clk);
    checkOutput("press_scan_stop_pre", scan_stop, 1'b0);
    @(negedge clk);
    checkOutput("press_scan_stop", scan_stop, 1'b1);
    for (int i = 0; i < DEBOUNCE_CYCLES; i++) begin
      @(negedge clk);
      checkOutput("press_latency_valid", key_valid, 1'b0);
      checkOutput("press_frozen_cols", cols_n, 4'b1101);
    end
    @(negedge clk);
    checkOutput("press_key_valid", key_valid, 1'b1);
    checkOutput("press_key_held", key_held, 1'b1);

    // Keep holding: repeat pulses only when the feature is built in.
    if (REPEAT_ON) begin
      exp_q.push_back(4'h5);
      exp_q.push_back(4'h5);
      exp_pulses = exp_pulses + 2;
    end
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      checkOutput("hold_repeat_valid", key_valid, REPEAT_ON && ((i % REPEAT_CYCLES) == 0));
    end
    checkOutput("hold_key_code", key_code, 4'h5);

    // Short release, re-press, then a full release.
    applyStimulus(4'b1111, 5);
    applyStimulus(4'b1101, 10);
    checkOutput("repress_key_held", key_held, 1'b1);
    applyStimulus(4'b1111, DEBOUNCE_CYCLES);
    n = 0;
    while (key_held !== 1'b0 && n < 6) begin
      @(negedge clk);
      n++;
    end
    checkOutput("release_key_held", key_held, 1'b0);
    waitCols(4'b1011, "release_next_col");
    checkOutput("release_scan_stop", scan_stop, 1'b0);
    checkOutput("release_key_code", key_code, 4'h5);
    checkOutput("release_valid_count", valid_count, exp_pulses);

    // Rows 0 and 2 together on column 2: row 0 wins -> key 3.
    rows_n = 4'b1010;
    exp_q.push_back(4'h3);
    exp_pulses = exp_pulses + 1;
    n = 0;
    while (key_held !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("multirow_key_held", key_held, 1'b1);
    checkOutput("multirow_key_code", key_code, 4'h3);

    // Reset while a key is held.
    reset  = 1'b0;
    rows_n = 4'hF;
    @(negedge clk);
    checkOutput("midrst_cols_n", cols_n, 4'b1110);
    checkOutput("midrst_key_held", key_held, 1'b0);
    checkOutput("midrst_key_code", key_code, 4'h0);
    checkOutput("midrst_key_valid", key_valid, 1'b0);
    checkOutput("midrst_scan_stop", scan_stop, 1'b0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("final_valid_count", valid_count, exp_pulses);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
